// File: rtl/fetch_unit.sv
// Instruction-fetch front end: sequential PC generation, req/gnt memory port,
// in-order fetch queue with wrong-path squash on Decode/Execute redirects.
module fetch_unit #(
    parameter int              XLEN     = 32,
    parameter int              DEPTH    = 2,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            StallF,
    input  logic            redirect_D,
    input  logic [XLEN-1:0] target_D,
    input  logic            redirect_E,
    input  logic [XLEN-1:0] target_E,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_gnt,
    input  logic            imem_rvalid,
    input  logic [31:0]     imem_rdata,
    output logic            valid_F,
    output logic [31:0]     instr_F,
    output logic [XLEN-1:0] pc_F,
    output logic [XLEN-1:0] pcplus4_F
);

    localparam int              CNT_W   = $clog2(DEPTH + 1);
    localparam int              DW      = CNT_W + 1;
    localparam int              PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
    localparam logic [PTR_W-1:0] LAST_P  = PTR_W'(DEPTH - 1);
    localparam logic [31:0]     NOP     = 32'h0000_0013;
    localparam logic [XLEN-1:0] FOUR    = XLEN'(4);

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == LAST_P) ? '0 : p + 1'b1;
    endfunction

    logic [XLEN-1:0]  pc;
    logic             started;
    logic [CNT_W-1:0] drop_cnt;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] ucnt;
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [PTR_W-1:0] fptr;
    logic [XLEN-1:0]  q_pc    [DEPTH];
    logic [31:0]      q_instr [DEPTH];
    logic [DEPTH-1:0] q_filled;

    logic             issue;
    logic             fill;
    logic             drop_hit;
    logic             pop;
    logic             redirect;
    logic [XLEN-1:0]  tgt;
    logic [DW-1:0]    occ;
    logic [DW-1:0]    drop_redir;
    logic             unused_bits;

    assign unused_bits = ^{target_E[1:0], target_D[1:0]};

    assign occ      = {1'b0, count} + {1'b0, drop_cnt};
    assign redirect = redirect_E | redirect_D;
    assign tgt      = redirect_E ? target_E : target_D;
    assign valid_F  = (count != '0) && q_filled[head];
    assign pop      = valid_F && !StallF && !redirect;

    // A full queue may still issue when its head leaves this cycle, which
    // keeps a zero-wait memory streaming at one instruction per cycle.
    assign imem_req  = started && ((occ < {1'b0, DEPTH_C}) || (pop && count == DEPTH_C));
    assign imem_addr = pc;
    assign issue     = imem_req && imem_gnt;
    assign drop_hit  = imem_rvalid && (drop_cnt != '0);
    assign fill      = imem_rvalid && (drop_cnt == '0) && (ucnt != '0);

    // Every request still owed a response becomes a word to discard.
    assign drop_redir = {1'b0, drop_cnt} + {1'b0, ucnt} + DW'(issue)
                      - DW'(drop_hit) - DW'(fill);

    assign instr_F   = valid_F ? q_instr[head] : NOP;
    assign pc_F      = valid_F ? q_pc[head] : '0;
    assign pcplus4_F = valid_F ? q_pc[head] + FOUR : '0;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pc       <= {RESET_PC[XLEN-1:2], 2'b00};
            started  <= 1'b0;
            drop_cnt <= '0;
            count    <= '0;
            ucnt     <= '0;
            head     <= '0;
            tail     <= '0;
            fptr     <= '0;
            q_filled <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                q_pc[i]    <= '0;
                q_instr[i] <= NOP;
            end
        end else begin
            started <= 1'b1;
            if (issue) q_pc[tail] <= pc;
            if (fill)  q_instr[fptr] <= imem_rdata;
            if (redirect) begin
                pc       <= {tgt[XLEN-1:2], 2'b00};
                count    <= '0;
                ucnt     <= '0;
                head     <= '0;
                tail     <= '0;
                fptr     <= '0;
                q_filled <= '0;
                drop_cnt <= drop_redir[CNT_W-1:0];
            end else begin
                if (issue) begin
                    pc             <= pc + FOUR;
                    tail           <= ptr_inc(tail);
                    q_filled[tail] <= 1'b0;
                end
                if (fill) begin
                    fptr           <= ptr_inc(fptr);
                    q_filled[fptr] <= 1'b1;
                end
                if (pop)      head     <= ptr_inc(head);
                if (drop_hit) drop_cnt <= drop_cnt - 1'b1;
                count <= count + CNT_W'(issue) - CNT_W'(pop);
                ucnt  <= ucnt + CNT_W'(issue) - CNT_W'(fill);
            end
        end
    end

    // A response with nothing outstanding means the memory broke ordering.
    rvalid_has_owner: assert property (@(posedge clk) disable iff (!reset_n)
        imem_rvalid |-> (drop_cnt != '0 || ucnt != '0));

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: in-order memory responder with programmable
// latency, hand-computed PC/instruction expectations per cycle.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        StallF;
    logic        redirect_D;
    logic [31:0] target_D;
    logic        redirect_E;
    logic [31:0] target_E;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        valid_F;
    logic [31:0] instr_F;
    logic [31:0] pc_F;
    logic [31:0] pcplus4_F;

    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam logic [31:0] KEY = 32'hA5A5_0000;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } mreq_t;

    mreq_t mq[$];
    int    errors = 0;
    int    checks = 0;
    int    cyc    = 0;
    int    lat    = 1;

    always #5 clk = ~clk;

    fetch_unit #(.XLEN(32), .DEPTH(2), .RESET_PC(32'h0)) dut (
        .clk(clk), .reset_n(reset_n), .StallF(StallF),
        .redirect_D(redirect_D), .target_D(target_D),
        .redirect_E(redirect_E), .target_E(target_E),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .valid_F(valid_F), .instr_F(instr_F), .pc_F(pc_F), .pcplus4_F(pcplus4_F)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance one clock; the responder records transfers before the edge and
    // returns words in order, one per cycle, lat cycles after the transfer.
    task automatic tick();
        @(negedge clk);
        if (reset_n && imem_req && imem_gnt) mq.push_back('{imem_addr, cyc + lat});
        @(posedge clk);
        #1;
        cyc++;
        if (mq.size() > 0 && mq[0].due <= cyc) begin
            imem_rvalid = 1'b1;
            imem_rdata  = mq[0].addr ^ KEY;
            void'(mq.pop_front());
        end else begin
            imem_rvalid = 1'b0;
            imem_rdata  = '0;
        end
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_req"},   32'(imem_req), 32'd0);
        check({tag, "_valid"}, 32'(valid_F),  32'd0);
        check({tag, "_instr"}, instr_F,       NOP);
        check({tag, "_pc"},    pc_F,          32'd0);
        check({tag, "_pc4"},   pcplus4_F,     32'd0);
    endtask

    task automatic check_head(input string tag, input logic [31:0] pc);
        check({tag, "_valid"}, 32'(valid_F), 32'd1);
        check({tag, "_pc"},    pc_F,         pc);
        check({tag, "_instr"}, instr_F,      pc ^ KEY);
        check({tag, "_pc4"},   pcplus4_F,    pc + 32'd4);
    endtask

    task automatic do_reset(input int l);
        reset_n     = 1'b0;
        StallF      = 1'b0;
        redirect_D  = 1'b0;
        redirect_E  = 1'b0;
        target_D    = '0;
        target_E    = '0;
        imem_gnt    = 1'b1;
        imem_rvalid = 1'b0;
        imem_rdata  = '0;
        mq.delete();
        lat = l;
        #1;
        check_idle("rst");
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        cyc     = 0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, expected finish");
        $fatal(1);
    end

    initial begin
        // 1: zero-wait streaming from reset
        do_reset(1);
        tick(); #1;
        check("t1_req_c1",   32'(imem_req), 32'd1);
        check("t1_addr_c1",  imem_addr,     32'h0);
        tick(); #1;
        check("t1_valid_c2", 32'(valid_F),  32'd0);
        check("t1_addr_c2",  imem_addr,     32'h4);
        for (int k = 3; k <= 5; k++) begin
            tick(); #1;
            check_head("t1_head", 32'((k - 3) * 4));
            check("t1_addr", imem_addr, 32'((k - 1) * 4));
        end

        // 2: stall with a full queue
        tick(); StallF = 1'b1; #1;
        check("t2_req_c6", 32'(imem_req), 32'd0);
        check_head("t2_c6", 32'd12);
        for (int k = 7; k <= 8; k++) begin
            tick(); #1;
            check("t2_req_hold", 32'(imem_req), 32'd0);
            check_head("t2_hold", 32'd12);
        end
        tick(); StallF = 1'b0; #1;
        check_head("t2_c9", 32'd12);
        check("t2_req_c9",  32'(imem_req), 32'd1);
        check("t2_addr_c9", imem_addr,     32'd20);
        tick(); #1;
        check_head("t2_c10", 32'd16);
        tick(); #1;
        check_head("t2_c11", 32'd20);

        // 3: latency 3, Execute redirect with two requests outstanding
        do_reset(3);
        tick(); #1;
        check("t3_addr_c1", imem_addr, 32'h0);
        tick(); #1;
        check("t3_addr_c2", imem_addr, 32'h4);
        tick(); redirect_E = 1'b1; target_E = 32'h100; #1;
        check("t3_req_c3", 32'(imem_req), 32'd0);
        tick(); redirect_E = 1'b0; #1;
        check("t3_req_c4",   32'(imem_req), 32'd0);
        check("t3_valid_c4", 32'(valid_F),  32'd0);
        tick(); #1;
        check("t3_req_c5",   32'(imem_req), 32'd1);
        check("t3_addr_c5",  imem_addr,     32'h100);
        tick(); #1;
        check("t3_addr_c6",  imem_addr,     32'h104);
        tick(); #1;
        check("t3_req_c7",   32'(imem_req), 32'd0);
        tick(); #1;
        check("t3_valid_c8", 32'(valid_F),  32'd0);
        tick(); #1;
        check_head("t3_c9", 32'h100);

        // 4: simultaneous Decode and Execute redirects under stall
        tick();
        StallF = 1'b1; redirect_D = 1'b1; target_D = 32'h40;
        redirect_E = 1'b1; target_E = 32'h200; #1;
        check("t4_req_c10", 32'(imem_req), 32'd0);
        check_head("t4_c10", 32'h104);
        tick(); StallF = 1'b0; redirect_D = 1'b0; redirect_E = 1'b0; #1;
        check("t4_valid_c11", 32'(valid_F), 32'd0);
        check("t4_instr_c11", instr_F,      NOP);
        check("t4_pc_c11",    pc_F,         32'd0);
        check("t4_pc4_c11",   pcplus4_F,    32'd0);
        check("t4_req_c11",   32'(imem_req), 32'd1);
        check("t4_addr_c11",  imem_addr,    32'h200);
        tick(); #1;
        check("t4_req_c12",   32'(imem_req), 32'd0);
        tick(); #1;
        check("t4_addr_c13",  imem_addr,    32'h204);
        tick(); tick(); #1;
        check_head("t4_c15", 32'h200);

        // 5: PC wrap at the top of the address space
        do_reset(1);
        tick(); redirect_E = 1'b1; target_E = 32'hFFFF_FFFE; #1;
        check("t5_addr_c1", imem_addr, 32'h0);
        tick(); redirect_E = 1'b0; #1;
        check("t5_addr_c2", imem_addr, 32'hFFFF_FFFC);
        tick(); #1;
        check("t5_req_c3",  32'(imem_req), 32'd1);
        check("t5_addr_c3", imem_addr,     32'h0);
        tick(); #1;
        check("t5_valid_c4", 32'(valid_F), 32'd1);
        check("t5_pc_c4",    pc_F,         32'hFFFF_FFFC);
        check("t5_pc4_c4",   pcplus4_F,    32'h0);
        check("t5_instr_c4", instr_F,      32'h5A5A_FFFC);

        // 6: asynchronous reset pulse with requests in flight
        #1;
        reset_n     = 1'b0;
        imem_rvalid = 1'b0;
        imem_rdata  = '0;
        mq.delete();
        #1;
        check_idle("t6_async");
        @(posedge clk); #1;
        reset_n = 1'b1;
        cyc     = 0;
        tick(); #1;
        check("t6_req_c1",   32'(imem_req), 32'd1);
        check("t6_addr_c1",  imem_addr,     32'h0);
        tick(); #1;
        check("t6_valid_c2", 32'(valid_F),  32'd0);
        tick(); #1;
        check_head("t6_c3", 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
